// File: rtl/axi_sram_slv.sv
// axi_sram_slv: AXI4 responder terminating one address window into a word-addressed memory.
// Define AXI_SRAM_SLV_ZERO_INIT_EN to clear the memory on reset (otherwise it is left uninitialised for RAM inference).
package axi_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  typedef struct packed {
    logic [31:0] idx;
    logic [63:0] start_addr;
    logic [63:0] end_addr;
  } xbar_rule_64_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic [0:0]  user;
  } aw_chan_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } ar_chan_t;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [0:0]  user;
  } w_chan_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } b_chan_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } r_chan_t;
  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module axi_sram_slv #(
  parameter int  AxiAddrWidth = 32,
  parameter int  AxiDataWidth = 64,
  parameter int  AxiIdWidth   = 4,
  parameter int  AxiUserWidth = 1,
  parameter int  Depth        = 512,
  parameter type rule_t       = axi_pkg::xbar_rule_64_t,
  parameter type req_t        = axi_pkg::req_t,
  parameter type resp_t       = axi_pkg::resp_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  test_i,
  input  req_t  slv_req_i,
  output resp_t slv_rsp_o,
  input  rule_t addr_map_i
);
  import axi_pkg::*;
  localparam int NB   = AxiDataWidth / 8;
  localparam int OffW = $clog2(NB);
  localparam int IdxW = $clog2(Depth);
  typedef logic [AxiAddrWidth-1:0] addr_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic logic in_range(input addr_t a, input rule_t m);
    logic [63:0] off;
    off = 64'(a) - m.start_addr;
    return 64'(a) >= m.start_addr && 64'(a) < m.end_addr && (off >> OffW) < 64'(Depth);
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input addr_t a, input rule_t m);
    logic [63:0] off;
    off = 64'(a) - m.start_addr;
    return IdxW'(off >> OffW);
  endfunction

  function automatic addr_t next_addr(input addr_t a, input logic [2:0] size, input logic [1:0] burst);
    return burst == BURST_FIXED ? a : a + (addr_t'(1) << size);
  endfunction

  logic [AxiDataWidth-1:0] mem_q [Depth];
  w_state_e w_q, w_d;
  r_state_e r_q, r_d;
  logic [AxiIdWidth-1:0] aw_id_q, ar_id_q;
  addr_t aw_addr_q, ar_addr_q, rd_addr;
  logic [2:0] aw_size_q, ar_size_q;
  logic [1:0] aw_burst_q, ar_burst_q, rd_burst, r_resp_q;
  logic [7:0] ar_len_q, beat_q;
  logic [AxiDataWidth-1:0] r_data_q;
  logic [IdxW-1:0] w_idx, r_idx;
  logic dec_err_q, aw_hs, w_hs, b_hs, ar_hs, r_hs, r_last, rd_load, w_ok, rd_ok, mem_we;
  logic [AxiUserWidth-1:0] unused_user;
  logic unused_bits;

  assign unused_user = slv_req_i.w.user;
  assign unused_bits = ^{test_i, addr_map_i.idx, slv_req_i.aw.len, slv_req_i.aw.lock, slv_req_i.aw.cache,
                         slv_req_i.aw.prot, slv_req_i.aw.qos, slv_req_i.aw.region, slv_req_i.aw.atop,
                         slv_req_i.aw.user, slv_req_i.ar.lock, slv_req_i.ar.cache, slv_req_i.ar.prot,
                         slv_req_i.ar.qos, slv_req_i.ar.region, slv_req_i.ar.user};

  assign aw_hs  = w_q == W_IDLE && slv_req_i.aw_valid;
  assign w_hs   = w_q == W_DATA && slv_req_i.w_valid;
  assign b_hs   = w_q == W_RESP && slv_req_i.b_ready;
  assign w_ok   = in_range(aw_addr_q, addr_map_i);
  assign w_idx  = word_idx(aw_addr_q, addr_map_i);
  assign mem_we = w_hs && w_ok && aw_burst_q != BURST_WRAP;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) w_q <= W_IDLE;
    else w_q <= w_d;

  always_comb w_d = aw_hs ? W_DATA : (w_hs && slv_req_i.w.last) ? W_RESP : b_hs ? W_IDLE : w_q;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      dec_err_q  <= 1'b0;
    end else if (aw_hs) begin
      aw_id_q    <= slv_req_i.aw.id;
      aw_addr_q  <= slv_req_i.aw.addr;
      aw_size_q  <= slv_req_i.aw.size;
      aw_burst_q <= slv_req_i.aw.burst;
      dec_err_q  <= 1'b0;
    end else if (w_hs) begin
      aw_addr_q  <= next_addr(aw_addr_q, aw_size_q, aw_burst_q);
      dec_err_q  <= dec_err_q | ~w_ok;
    end

`ifdef AXI_SRAM_SLV_ZERO_INIT_EN
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    else if (mem_we)
      for (int b = 0; b < NB; b++) if (slv_req_i.w.strb[b]) mem_q[w_idx][8*b +: 8] <= slv_req_i.w.data[8*b +: 8];
`else
  always_ff @(posedge clk_i)
    if (mem_we)
      for (int b = 0; b < NB; b++) if (slv_req_i.w.strb[b]) mem_q[w_idx][8*b +: 8] <= slv_req_i.w.data[8*b +: 8];
`endif

  // The read port looks one beat ahead so the next beat is ready the cycle after each handshake.
  assign ar_hs    = r_q == R_IDLE && slv_req_i.ar_valid;
  assign r_last   = beat_q == ar_len_q;
  assign r_hs     = r_q == R_DATA && slv_req_i.r_ready;
  assign rd_load  = ar_hs || (r_hs && !r_last);
  assign rd_addr  = r_q == R_IDLE ? slv_req_i.ar.addr : next_addr(ar_addr_q, ar_size_q, ar_burst_q);
  assign rd_burst = r_q == R_IDLE ? slv_req_i.ar.burst : ar_burst_q;
  assign rd_ok    = in_range(rd_addr, addr_map_i);
  assign r_idx    = word_idx(rd_addr, addr_map_i);

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_q <= R_IDLE;
    else r_q <= r_d;

  always_comb r_d = ar_hs ? R_DATA : (r_hs && r_last) ? R_IDLE : r_q;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      ar_id_q    <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      ar_addr_q  <= '0;
      beat_q     <= '0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else if (rd_load) begin
      if (ar_hs) begin
        ar_id_q    <= slv_req_i.ar.id;
        ar_len_q   <= slv_req_i.ar.len;
        ar_size_q  <= slv_req_i.ar.size;
        ar_burst_q <= slv_req_i.ar.burst;
      end
      ar_addr_q <= rd_addr;
      beat_q    <= ar_hs ? 8'd0 : beat_q + 8'd1;
      r_data_q  <= rd_ok && rd_burst != BURST_WRAP ? mem_q[r_idx] : '0;
      r_resp_q  <= rd_burst == BURST_WRAP ? RESP_SLVERR : rd_ok ? RESP_OKAY : RESP_DECERR;
    end

  always_comb begin
    slv_rsp_o          = '0;
    slv_rsp_o.aw_ready = w_q == W_IDLE;
    slv_rsp_o.w_ready  = w_q == W_DATA;
    slv_rsp_o.b_valid  = w_q == W_RESP;
    slv_rsp_o.ar_ready = r_q == R_IDLE;
    slv_rsp_o.r_valid  = r_q == R_DATA;
    slv_rsp_o.b.id     = w_q == W_RESP ? aw_id_q : '0;
    slv_rsp_o.b.resp   = w_q != W_RESP ? RESP_OKAY : aw_burst_q == BURST_WRAP ? RESP_SLVERR :
                         dec_err_q ? RESP_DECERR : RESP_OKAY;
    slv_rsp_o.r.id     = r_q == R_DATA ? ar_id_q : '0;
    slv_rsp_o.r.data   = r_q == R_DATA ? r_data_q : '0;
    slv_rsp_o.r.resp   = r_q == R_DATA ? r_resp_q : RESP_OKAY;
    slv_rsp_o.r.last   = r_q == R_DATA && r_last;
  end
endmodule
